// File: rtl/cgra_tcdm_responder.sv
// Multi-port TCDM responder: word-interleaved SRAM banks with per-bank round-robin
// arbitration and fixed-latency, non-backpressurable responses.
module cgra_tcdm_responder #(
    parameter int unsigned NumPorts     = 4,
    parameter int unsigned NumBanks     = 4,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned AddrWidth    = 48,
    parameter int unsigned WordsPerBank = 64,
    parameter int unsigned ReadLatency  = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumPorts-1:0]                     tcdm_req_q_valid_i,
    output logic [NumPorts-1:0]                     tcdm_req_q_ready_o,
    input  logic [NumPorts-1:0]                     tcdm_req_write_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]      tcdm_req_addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]      tcdm_req_data_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0]    tcdm_req_strb_i,
    input  logic [NumPorts-1:0][3:0]                tcdm_req_amo_i,
    output logic [NumPorts-1:0]                     tcdm_rsp_p_valid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]      tcdm_rsp_data_o,
    output logic                                    err_o,
    output logic [15:0]                             conflict_cnt_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned BO        = $clog2(StrbWidth);
    localparam int unsigned LB        = $clog2(NumBanks);
    localparam int unsigned RW        = $clog2(WordsPerBank);
    localparam int unsigned PW        = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned WW        = AddrWidth - BO;
    localparam int unsigned NumWords  = NumBanks * WordsPerBank;

    logic [LB-1:0]        port_bank [NumPorts];
    logic [RW-1:0]        port_row  [NumPorts];
    logic [NumPorts-1:0]  port_oor;
    logic [NumPorts-1:0]  port_amo;
    logic [NumPorts-1:0]  handshake;
    logic [NumBanks-1:0]  bank_gnt;
    logic [PW-1:0]        bank_win   [NumBanks];
    logic [DataWidth-1:0] bank_rdata [NumBanks];

    logic        err_reg;
    logic [15:0] conflict_cnt_reg;

    genvar gi;

    // Address decode and request acceptance; out-of-range requests skip the banks.
    for (gi = 0; gi < NumPorts; gi++) begin : g_port_decode
        logic [WW-1:0] word;
        assign word           = tcdm_req_addr_i[gi][AddrWidth-1:BO];
        assign port_bank[gi]  = word[LB-1:0];
        assign port_row[gi]   = word[LB +: RW];
        assign port_oor[gi]   = (word >= WW'(NumWords)) || (tcdm_req_addr_i[gi][BO-1:0] != '0);
        assign port_amo[gi]   = (tcdm_req_amo_i[gi] != 4'd0);
        assign tcdm_req_q_ready_o[gi] = !rst_i && tcdm_req_q_valid_i[gi] &&
            (port_oor[gi] || (bank_gnt[port_bank[gi]] && (bank_win[port_bank[gi]] == PW'(gi))));
    end

    assign handshake = tcdm_req_q_valid_i & tcdm_req_q_ready_o;

    for (gi = 0; gi < NumBanks; gi++) begin : g_bank
        logic [NumPorts-1:0]  req;
        logic                 gnt;
        logic [PW-1:0]        win;
        logic [PW-1:0]        ptr_reg;
        int                   idx;
        logic [RW-1:0]        row;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] strb;
        logic                 is_write;
        logic [DataWidth-1:0] mem [WordsPerBank];
        logic [DataWidth-1:0] rdata_reg;

        always_comb begin
            req = '0;
            for (int p = 0; p < NumPorts; p++) begin
                req[p] = tcdm_req_q_valid_i[p] && !port_oor[p] && (port_bank[p] == LB'(gi));
            end
        end

        // First requester found scanning upward from the pointer wins.
        always_comb begin
            gnt = 1'b0;
            win = ptr_reg;
            idx = 0;
            for (int k = 0; k < NumPorts; k++) begin
                idx = (int'(ptr_reg) + k) % int'(NumPorts);
                if (!gnt && req[idx]) begin
                    gnt = 1'b1;
                    win = PW'(idx);
                end
            end
        end

        assign row      = port_row[win];
        assign wdata    = tcdm_req_data_i[win];
        assign strb     = tcdm_req_strb_i[win];
        assign is_write = tcdm_req_write_i[win];

        always_ff @(posedge clk_i) begin
            if (gnt && is_write && !rst_i) begin
                for (int b = 0; b < int'(StrbWidth); b++) begin
                    if (strb[b]) begin
                        mem[row][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
            if (gnt && !is_write) begin
                rdata_reg <= mem[row];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ptr_reg <= '0;
            end else if (gnt) begin
                ptr_reg <= PW'((int'(win) + 1) % int'(NumPorts));
            end
        end

        assign bank_gnt[gi]   = gnt;
        assign bank_win[gi]   = win;
        assign bank_rdata[gi] = rdata_reg;
    end

    for (gi = 0; gi < NumPorts; gi++) begin : g_port_rsp
        logic                 s1_valid_reg;
        logic                 s1_zero_reg;
        logic [LB-1:0]        s1_bank_reg;
        logic [DataWidth-1:0] s1_data;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s1_valid_reg <= 1'b0;
            end else begin
                s1_valid_reg <= handshake[gi];
            end
        end

        always_ff @(posedge clk_i) begin
            s1_zero_reg <= tcdm_req_write_i[gi] || port_oor[gi];
            s1_bank_reg <= port_bank[gi];
        end

        // Writes and out-of-range accesses answer with zero instead of bank data.
        assign s1_data = (s1_valid_reg && !s1_zero_reg) ? bank_rdata[s1_bank_reg] : '0;

        if (ReadLatency == 1) begin : g_direct
            assign tcdm_rsp_p_valid_o[gi] = s1_valid_reg;
            assign tcdm_rsp_data_o[gi]    = s1_data;
        end else begin : g_pipe
            logic [ReadLatency-2:0] valid_pipe_reg;
            logic [DataWidth-1:0]   data_pipe_reg [ReadLatency-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_pipe_reg <= '0;
                    for (int i = 0; i < int'(ReadLatency) - 1; i++) begin
                        data_pipe_reg[i] <= '0;
                    end
                end else begin
                    valid_pipe_reg[0] <= s1_valid_reg;
                    data_pipe_reg[0]  <= s1_data;
                    for (int i = 1; i < int'(ReadLatency) - 1; i++) begin
                        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                        data_pipe_reg[i]  <= data_pipe_reg[i-1];
                    end
                end
            end

            assign tcdm_rsp_p_valid_o[gi] = valid_pipe_reg[ReadLatency-2];
            assign tcdm_rsp_data_o[gi]    = data_pipe_reg[ReadLatency-2];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg          <= 1'b0;
            conflict_cnt_reg <= 16'd0;
        end else begin
            if (|(handshake & (port_oor | port_amo))) begin
                err_reg <= 1'b1;
            end
            if (|(tcdm_req_q_valid_i & ~tcdm_req_q_ready_o) && (conflict_cnt_reg != 16'hFFFF)) begin
                conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
            end
        end
    end

    assign err_o          = err_reg;
    assign conflict_cnt_o = conflict_cnt_reg;

endmodule
